// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared datapath widths and register-address type
package proc_pkg;
    localparam int WORD_W    = 32;
    localparam int REG_DEPTH = 32;
    localparam int REG_AW    = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;
endpackage

// File: rtl/reg_rd_port.sv
// rtl/reg_rd_port.sv - one register-file read port: mux, r0 masking, bypass, optional output register
module reg_rd_port
    import proc_pkg::*;
#(
    parameter int WIDTH   = WORD_W,
    parameter int DEPTH   = REG_DEPTH,
    parameter int AW      = REG_AW,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1,
    parameter bit REG_OUT = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DEPTH*WIDTH-1:0] mem_flat,
    input  logic                   re,
    input  logic [AW-1:0]          raddr,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata
);
    logic             r0_hit;
    logic             bypass_hit;
    logic [WIDTH-1:0] rd_val;

    assign r0_hit     = ZERO_R0 && (raddr == '0);
    // A suppressed r0 write never reaches storage, so it must not be forwarded either.
    assign bypass_hit = BYPASS && we && (waddr == raddr) && !r0_hit;

    always_comb begin
        rd_val = mem_flat[int'(raddr) * WIDTH +: WIDTH];
        if (r0_hit) begin
            rd_val = '0;
        end else if (bypass_hit) begin
            rd_val = wdata;
        end
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] rdata_q;
        logic [WIDTH-1:0] rdata_d;

        assign rdata_d = re ? rd_val : rdata_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata = rdata_q;
    end else begin : g_comb
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst_n, re};
        assign rdata     = rd_val;
    end
endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - parametrised multi-read, single-write register file
module reg_file
    import proc_pkg::*;
#(
    parameter int WIDTH   = WORD_W,
    parameter int DEPTH   = REG_DEPTH,
    parameter int NRD     = 2,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1,
    parameter bit REG_OUT = 1'b0,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [NRD-1:0]       re,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata
);
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [DEPTH-1:0][WIDTH-1:0] mem_d;
    logic                        wr_en;

    assign wr_en = we && !(ZERO_R0 && (waddr == '0));

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        reg_rd_port #(
            .WIDTH   (WIDTH),
            .DEPTH   (DEPTH),
            .AW      (AW),
            .ZERO_R0 (ZERO_R0),
            .BYPASS  (BYPASS),
            .REG_OUT (REG_OUT)
        ) u_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .mem_flat (mem_q),
            .re       (re[i]),
            .raddr    (raddr[i*AW +: AW]),
            .we       (we),
            .waddr    (waddr),
            .wdata    (wdata),
            .rdata    (rdata[i*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file across several configurations
module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rd_a;
    logic [63:0] rd_b;
    logic [63:0] rd_c;

    logic        d_we;
    logic [1:0]  d_waddr;
    logic [7:0]  d_wdata;
    logic [2:0]  d_re;
    logic [5:0]  d_raddr;
    logic [23:0] rd_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // a: r0 zero, bypass, combinational read
    reg_file #(.ZERO_R0(1'b1), .BYPASS(1'b1), .REG_OUT(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rd_a));

    // b: writable r0, no bypass, combinational read
    reg_file #(.ZERO_R0(1'b0), .BYPASS(1'b0), .REG_OUT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rd_b));

    // c: no bypass, registered read
    reg_file #(.ZERO_R0(1'b1), .BYPASS(1'b0), .REG_OUT(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rd_c));

    // d: narrow, shallow, three read ports
    reg_file #(.WIDTH(8), .DEPTH(4), .NRD(3)) dut_d (
        .clk(clk), .rst_n(rst_n), .we(d_we), .waddr(d_waddr), .wdata(d_wdata),
        .re(d_re), .raddr(d_raddr), .rdata(rd_d));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        re      = '0;
        raddr   = '0;
        d_we    = 1'b0;
        d_waddr = '0;
        d_wdata = '0;
        d_re    = '0;
        d_raddr = '0;
        #2;
        check("reset_a_p0", rd_a[31:0], 32'h0);
        check("reset_c_p0", rd_c[31:0], 32'h0);
        check("reset_d_p2", {8'h0, rd_d[23:16]}, 32'h0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            we    = 1'b1;
            waddr = 5'(i);
            wdata = 32'hA5A5_0000 + 32'(i);
            step();
        end
        we    = 1'b0;
        raddr = {5'd0, 5'd5};
        #1;
        check("fill_a_r5", rd_a[31:0], 32'hA5A5_0005);
        check("fill_b_r0", rd_b[63:32], 32'hA5A5_0000);
        check("fill_a_r0", rd_a[63:32], 32'h0);

        rst_n = 1'b0;
        #3;
        check("midrst_a_r5", rd_a[31:0], 32'h0);
        check("midrst_b_r0", rd_b[63:32], 32'h0);
        check("midrst_c_p0", rd_c[31:0], 32'h0);
        rst_n = 1'b1;

        we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
        step();
        we = 1'b0; raddr = {5'd7, 5'd7};
        #1;
        check("wr_r7_p0", rd_a[31:0], 32'hDEAD_BEEF);
        check("wr_r7_p1", rd_a[63:32], 32'hDEAD_BEEF);

        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        step();
        we = 1'b0; raddr = {5'd7, 5'd0};
        #1;
        check("r0_zero", rd_a[31:0], 32'h0);
        check("r0_plain", rd_b[31:0], 32'hFFFF_FFFF);

        we = 1'b1; waddr = 5'd3; wdata = 32'h1111_1111;
        step();
        wdata = 32'h2222_2222; raddr = {5'd7, 5'd3}; re = 2'b01;
        #1;
        check("bypass_on", rd_a[31:0], 32'h2222_2222);
        check("bypass_off_same", rd_b[31:0], 32'h1111_1111);
        step();
        we = 1'b0; re = 2'b00;
        #1;
        check("bypass_off_next", rd_b[31:0], 32'h2222_2222);
        check("regout_prewrite", rd_c[31:0], 32'h1111_1111);

        we = 1'b1; waddr = 5'd5; wdata = 32'h55;
        step();
        waddr = 5'd6; wdata = 32'h66;
        step();
        we = 1'b0; raddr = {5'd6, 5'd5}; re = 2'b01;
        #1;
        check("regout_before_edge", rd_c[31:0], 32'h1111_1111);
        step();
        check("regout_p0", rd_c[31:0], 32'h55);
        check("regout_p1_hold", rd_c[63:32], 32'h0);
        re = 2'b10;
        step();
        check("regout_p1", rd_c[63:32], 32'h66);
        check("regout_p0_hold", rd_c[31:0], 32'h55);
        re = 2'b00;

        for (int i = 1; i < 4; i++) begin
            d_we    = 1'b1;
            d_waddr = 2'(i);
            d_wdata = 8'(i);
            step();
        end
        d_we    = 1'b0;
        d_raddr = {2'd3, 2'd2, 2'd1};
        #1;
        check("sweep_p0", {24'h0, rd_d[7:0]}, 32'h01);
        check("sweep_p1", {24'h0, rd_d[15:8]}, 32'h02);
        check("sweep_p2", {24'h0, rd_d[23:16]}, 32'h03);
        d_we = 1'b1; d_waddr = 2'd2; d_wdata = 8'h7E;
        #1;
        check("sweep_bypass", {24'h0, rd_d[15:8]}, 32'h7E);
        check("sweep_other", {24'h0, rd_d[23:16]}, 32'h03);
        step();
        d_we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
